scoreboard_digits: RTL and testbench

- Two-player BCD score keeper and score-overlay pixel generator.
- Sits directly upstream of the 5x5 digit bitmap ROM. It drives the ROM's digit/yofs inputs from the beam position, consumes the returned 5-bit row, and produces a registered 1-bit score pixel for the video mixer.
- Score updates reach the display only outside the active area, so no digit tears mid-frame.

---
 rtl/scoreboard_pkg.sv | 27 ++
 rtl/scoreboard_digits_bcd2_counter.sv | 34 +++
 rtl/scoreboard_digits.sv | 132 +++++++++++++
 tb/tb_scoreboard_digits.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared geometry, digit codes and commit-FSM encoding for the score overlay.
// Optional build macro: SCOREBOARD_LEADING_ZERO_BLANK_EN (blanks a tens digit of 0).
package scoreboard_pkg;

   localparam logic [8:0] CELL_W      = 9'd16;
   localparam logic [8:0] CELL_H      = 9'd16;
   localparam logic [2:0] GLYPH_W     = 3'd5;
   localparam logic [2:0] GLYPH_H     = 3'd5;
   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam int         BCD2_W      = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } commit_state_t;

   // Select the tens or ones digit of a 2-digit BCD score for the ROM.
   function automatic logic [3:0] pick_digit(input logic [BCD2_W-1:0] score,
                                             input logic              ones);
      if (ones) return score[3:0];
`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
      if (score[7:4] == 4'd0) return DIGIT_BLANK;
`endif
      return score[7:4];
   endfunction

endpackage

// File: rtl/scoreboard_digits_bcd2_counter.sv
// Two-digit BCD counter that saturates at 99. clear beats inc; hold blocks inc.
// count_next/changed are exposed so the owner can track pending updates.
module bcd2_counter
   import scoreboard_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clear,
   input  logic              hold,
   output logic [BCD2_W-1:0] count,
   output logic [BCD2_W-1:0] count_next,
   output logic              changed
);

   // Next value: clear, else decimal increment unless held or already 99.
   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (inc && !hold && (count != 8'h99)) begin
         if (count[3:0] == 4'd9) count_next = {count[7:4] + 4'd1, 4'd0};
         else                    count_next = {count[7:4], count[3:0] + 4'd1};
      end
      changed = (count_next != count);
   end

   // Score register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count <= '0;
      else        count <= count_next;
   end

endmodule

// File: rtl/scoreboard_digits.sv
// Two-player BCD score keeper and score-overlay pixel generator feeding a 5x5 digit ROM.
// Optional build macro: SCOREBOARD_LEADING_ZERO_BLANK_EN (see scoreboard_pkg).
//
// state   | meaning
// IDLE    | display copy matches live scores
// PENDING | live scores changed, waiting for the commit scanline
module scoreboard_digits
   import scoreboard_pkg::*;
#(
   parameter logic [8:0]        SCORE_Y     = 9'd16,
   parameter logic [8:0]        P1_X        = 9'd32,
   parameter logic [8:0]        P2_X        = 9'd192,
   parameter logic [8:0]        COMMIT_LINE = 9'd240,
   parameter logic [BCD2_W-1:0] WIN_SCORE   = 8'h15
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        hpos,
   input  logic [8:0]        vpos,
   input  logic              display_on,
   input  logic              inc_p1,
   input  logic              inc_p2,
   input  logic              clear,
   output logic [3:0]        digit,
   output logic [2:0]        yofs,
   input  logic [4:0]        bits,
   output logic              score_pixel,
   output logic [BCD2_W-1:0] p1_score,
   output logic [BCD2_W-1:0] p2_score,
   output logic              win,
   output logic              update_pending
);

   logic [BCD2_W-1:0] p1_next, p2_next, disp_p1, disp_p2;
   logic              p1_chg, p2_chg, commit;
   commit_state_t     state, state_next;

   assign win = (p1_score >= WIN_SCORE) || (p2_score >= WIN_SCORE);

   bcd2_counter u_p1 (
      .clk(clk), .reset(reset), .inc(inc_p1), .clear(clear), .hold(win),
      .count(p1_score), .count_next(p1_next), .changed(p1_chg)
   );

   bcd2_counter u_p2 (
      .clk(clk), .reset(reset), .inc(inc_p2), .clear(clear), .hold(win),
      .count(p2_score), .count_next(p2_next), .changed(p2_chg)
   );

   // Commit decision: the commit cycle always lands in IDLE with fresh display values.
   always_comb begin
      state_next = state;
      commit     = (vpos == COMMIT_LINE) && (hpos == 9'd0);
      if (commit)                state_next = IDLE;
      else if (p1_chg || p2_chg) state_next = PENDING;
   end

   // State register and display copy, loaded from the post-update live value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         disp_p1 <= '0;
         disp_p2 <= '0;
      end else begin
         state <= state_next;
         if (commit) begin
            disp_p1 <= p1_next;
            disp_p2 <= p2_next;
         end
      end
   end

   assign update_pending = (state == PENDING);

   logic [8:0] rel_y, rel_x1, rel_x2;
   logic       row_hit, p1_hit, p2_hit;
   logic [3:0] digit_d;
   logic [2:0] yofs_d, xofs_d, xofs_q, glyph_col;
   logic       inbox_d, inbox_q, don_q;

   // Stage-1 decode: which cell the beam is in and which ROM row/column it needs.
   always_comb begin
      rel_y   = vpos - SCORE_Y;
      rel_x1  = hpos - P1_X;
      rel_x2  = hpos - P2_X;
      row_hit = (vpos >= SCORE_Y) && (rel_y < CELL_H) && (rel_y[3:1] < GLYPH_H);
      p1_hit  = (hpos >= P1_X) && (rel_x1 < (CELL_W + CELL_W));
      p2_hit  = (hpos >= P2_X) && (rel_x2 < (CELL_W + CELL_W));
      digit_d = DIGIT_BLANK;
      yofs_d  = 3'd0;
      xofs_d  = 3'd0;
      inbox_d = 1'b0;
      if (row_hit && p1_hit) begin
         digit_d = pick_digit(disp_p1, rel_x1[4]);
         yofs_d  = rel_y[3:1];
         xofs_d  = rel_x1[3:1];
         inbox_d = 1'b1;
      end else if (row_hit && p2_hit) begin
         digit_d = pick_digit(disp_p2, rel_x2[4]);
         yofs_d  = rel_y[3:1];
         xofs_d  = rel_x2[3:1];
         inbox_d = 1'b1;
      end
   end

   // Stage-1 registers driving the ROM address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit   <= DIGIT_BLANK;
         yofs    <= 3'd0;
         xofs_q  <= 3'd0;
         inbox_q <= 1'b0;
         don_q   <= 1'b0;
      end else begin
         digit   <= digit_d;
         yofs    <= yofs_d;
         xofs_q  <= xofs_d;
         inbox_q <= inbox_d;
         don_q   <= display_on;
      end
   end

   // Bit 4 of the ROM row is the leftmost glyph column.
   assign glyph_col = 3'd4 - xofs_q;

   // Stage-2: pick the glyph bit for this column.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) score_pixel <= 1'b0;
      else        score_pixel <= inbox_q && don_q && (xofs_q < GLYPH_W) && bits[glyph_col];
   end

endmodule

// File: tb/tb_scoreboard_digits.sv
module tb_scoreboard_digits;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [8:0] hpos = '0, vpos = '0;
   logic       display_on = 1'b1;
   logic       inc_p1 = 1'b0, inc_p2 = 1'b0, clear = 1'b0, inc2 = 1'b0;
   logic [3:0] digit;
   logic [2:0] yofs;
   logic [4:0] bits;
   logic       score_pixel, win, update_pending;
   logic [7:0] p1_score, p2_score;

   logic [3:0] s_digit;
   logic [2:0] s_yofs;
   logic       s_pixel, s_win, s_pend;
   logic [7:0] s_p1, s_p2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   scoreboard_digits dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .inc_p1(inc_p1), .inc_p2(inc_p2), .clear(clear), .digit(digit), .yofs(yofs),
      .bits(bits), .score_pixel(score_pixel), .p1_score(p1_score), .p2_score(p2_score),
      .win(win), .update_pending(update_pending)
   );

   scoreboard_digits #(.WIN_SCORE(8'hA0)) sat (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .inc_p1(inc2), .inc_p2(1'b0), .clear(clear), .digit(s_digit), .yofs(s_yofs),
      .bits(5'b00000), .score_pixel(s_pixel), .p1_score(s_p1), .p2_score(s_p2),
      .win(s_win), .update_pending(s_pend)
   );

   // Small digit ROM model: only glyphs 0 and 1 are detailed.
   always_comb begin
      bits = 5'b00000;
      if (digit == 4'd0) bits = (yofs == 3'd0 || yofs == 3'd4) ? 5'b11111 : 5'b10001;
      else if (digit == 4'd1) begin
         case (yofs)
            3'd0:    bits = 5'b01100;
            3'd4:    bits = 5'b01110;
            default: bits = 5'b00100;
         endcase
      end else if (digit != 4'hF) bits = 5'b10101;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic a, input logic b, input logic c, input int n = 1);
      repeat (n) begin
         inc_p1 = a; inc_p2 = b; clear = c;
         step();
         inc_p1 = 1'b0; inc_p2 = 1'b0; clear = 1'b0;
      end
   endtask

   task automatic beam(input logic [8:0] h, input logic [8:0] v);
      hpos = h; vpos = v;
      step();
   endtask

   initial begin
      step(2);
      chk("rst_digit", digit, 4'hF);
      chk("rst_yofs", yofs, 3'd0);
      chk("rst_pixel", score_pixel, 1'b0);
      chk("rst_p1", p1_score, 8'h00);
      chk("rst_p2", p2_score, 8'h00);
      chk("rst_pend", update_pending, 1'b0);
      chk("rst_win", win, 1'b0);
      reset = 1'b1;

      pulse(1, 0, 0, 10);
      chk("p1_carry", p1_score, 8'h10);
      pulse(1, 0, 0, 1);
      chk("p1_11", p1_score, 8'h11);
      chk("pend_set", update_pending, 1'b1);
      beam(9'd48, 9'd16);
      chk("disp_old", digit, 4'd0);
      beam(9'd0, 9'd240);
      chk("pend_clr", update_pending, 1'b0);

      beam(9'd48, 9'd16);
      chk("ones_digit", digit, 4'd1);
      chk("ones_yofs", yofs, 3'd0);
      step();
      chk("pix_x48", score_pixel, 1'b0);
      beam(9'd52, 9'd16);
      step();
      chk("pix_x52", score_pixel, 1'b1);
      beam(9'd32, 9'd16);
      chk("tens_digit", digit, 4'd1);
      beam(9'd192, 9'd16);
      chk("p2_tens", digit, 4'd0);
      beam(9'd48, 9'd26);
      chk("row_blank", digit, 4'hF);
      beam(9'd48, 9'd18);
      chk("yofs1", yofs, 3'd1);
      beam(9'd100, 9'd16);
      chk("gap_blank", digit, 4'hF);

      beam(9'd52, 9'd16);
      step();
      chk("pre_rst_pix", score_pixel, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_pix", score_pixel, 1'b0);
      chk("mid_rst_digit", digit, 4'hF);
      chk("mid_rst_p1", p1_score, 8'h00);
      step(2);
      hpos = 9'd48; vpos = 9'd16;
      reset = 1'b1;
      step();
      chk("rel_digit", digit, 4'd0);
      chk("rel_pix1", score_pixel, 1'b0);
      step();
      chk("rel_pix2", score_pixel, 1'b1);

      hpos = 9'd0; vpos = 9'd0;
      pulse(1, 1, 0);
      chk("both_p1", p1_score, 8'h01);
      chk("both_p2", p2_score, 8'h01);
      pulse(1, 1, 1);
      chk("clr_pri_p1", p1_score, 8'h00);
      chk("clr_pri_p2", p2_score, 8'h00);
      pulse(1, 1, 0);
      chk("both2_p1", p1_score, 8'h01);
      chk("both2_p2", p2_score, 8'h01);

      pulse(0, 0, 1);
      pulse(0, 1, 0, 14);
      chk("p2_14", p2_score, 8'h14);
      chk("win_14", win, 1'b0);
      pulse(0, 1, 0);
      chk("p2_15", p2_score, 8'h15);
      chk("win_15", win, 1'b1);
      pulse(0, 1, 0);
      chk("win_hold_p2", p2_score, 8'h15);
      pulse(1, 0, 0);
      chk("win_hold_p1", p1_score, 8'h00);
      pulse(0, 0, 1);
      chk("win_clr_p2", p2_score, 8'h00);
      chk("win_clr", win, 1'b0);

      beam(9'd0, 9'd240);
      chk("tear_idle", update_pending, 1'b0);
      hpos = 9'd0; vpos = 9'd100;
      pulse(0, 1, 0);
      chk("tear_p2", p2_score, 8'h01);
      chk("tear_pend", update_pending, 1'b1);
      beam(9'd208, 9'd16);
      chk("tear_old", digit, 4'd0);
      beam(9'd0, 9'd239);
      chk("tear_pend239", update_pending, 1'b1);
      beam(9'd5, 9'd240);
      chk("tear_pend_h5", update_pending, 1'b1);
      hpos = 9'd0; vpos = 9'd240;
      pulse(1, 0, 0);
      chk("commit_chg_pend", update_pending, 1'b0);
      chk("commit_chg_p1", p1_score, 8'h01);
      beam(9'd208, 9'd16);
      chk("tear_new", digit, 4'd1);
      beam(9'd48, 9'd16);
      chk("commit_chg_disp", digit, 4'd1);

      hpos = 9'd0; vpos = 9'd0;
      pulse(0, 0, 1);
      repeat (9) begin inc2 = 1'b1; step(); inc2 = 1'b0; end
      chk("sat_09", s_p1, 8'h09);
      inc2 = 1'b1; step(); inc2 = 1'b0;
      chk("sat_10", s_p1, 8'h10);
      repeat (89) begin inc2 = 1'b1; step(); inc2 = 1'b0; end
      chk("sat_99", s_p1, 8'h99);
      inc2 = 1'b1; step(); inc2 = 1'b0;
      chk("sat_hold", s_p1, 8'h99);
      chk("sat_nowin", s_win, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
